systolic_array_controller: RTL and testbench

Sequencer for a weight-stationary systolic array of ARRAY_ROWS x ARRAY_COLS processing elements. Each PE registers activations in 1 cycle and psums in 2 cycles. Per job, the block:
- optionally loads the stationary weights, one row per cycle;
- streams cfg_num_vectors activation vectors with per-row skew;
- drains the pipeline and flags the valid result columns.

It owns the array-wide pe_enable and stalls the whole array when the result consumer backpressures.

---
 rtl/systolic_pkg.sv | 27 ++
 rtl/sa_delay_line.sv | 26 ++
 rtl/systolic_array_controller.sv | 254 +++++++++++++++++++++++++
 tb/tb_systolic_array_controller.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and sizing helpers for the systolic array sequencer.
// Holds the job state enum, default array geometry and the pipeline latency formula.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } sa_state_e;

    localparam int DEF_ARRAY_ROWS = 4;
    localparam int DEF_ARRAY_COLS = 4;
    localparam int DEF_ROW_SKEW   = 2;

    // Row-0 activation entry to first bottom-row psum: skew across rows,
    // 2-cycle PE psum stage, then the column ripple.
    function automatic int calc_pipe_lat(
        input int rows,
        input int cols,
        input int skew
    );
        return skew * (rows - 1) + 2 + cols - 1;
    endfunction

endpackage

// File: rtl/sa_delay_line.sv
// sa_delay_line: 1-bit delay of DEPTH cycles (DEPTH >= 1) with hold enable.
// Used for the activation lane skew taps and the result-valid pipe.
module sa_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sr;

    // Advance one stage per enabled cycle; freeze while the array is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= (r_sr << 1) | DEPTH'(i_d);
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/systolic_array_controller.sv
// systolic_array_controller: job sequencer for a weight-stationary systolic array.
// Optional SA_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module systolic_array_controller
    import systolic_pkg::*;
#(
    parameter int ARRAY_ROWS = DEF_ARRAY_ROWS,
    parameter int ARRAY_COLS = DEF_ARRAY_COLS,
    parameter int CNT_W      = 16,
    parameter int ROW_SKEW   = DEF_ROW_SKEW,
    parameter int PIPE_LAT   = calc_pipe_lat(ARRAY_ROWS, ARRAY_COLS, ROW_SKEW),
    localparam int RA_W      = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [CNT_W-1:0]      cfg_num_vectors,
    input  logic                  cfg_load_weights,
    output logic                  wt_rd_en,
    output logic [RA_W-1:0]       wt_rd_row,
    output logic [ARRAY_ROWS-1:0] load_weight_en,
    output logic                  act_rd_en,
    output logic [CNT_W-1:0]      act_rd_idx,
    output logic [ARRAY_ROWS-1:0] act_lane_en,
    output logic                  pe_enable,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_W-1:0]      res_idx,
    output logic                  busy,
`ifdef SA_CTRL_PERF_EN
    output logic [31:0]           perf_busy_cycles,
    output logic [31:0]           perf_stall_cycles,
`endif
    output logic                  done
);

    localparam logic [RA_W:0]      ROW_END = (RA_W + 1)'(ARRAY_ROWS);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    sa_state_e             r_state;
    sa_state_e             w_next;
    logic [CNT_W-1:0]      r_num;
    logic [CNT_W-1:0]      r_vec;
    logic [CNT_W-1:0]      r_acc;
    logic [RA_W:0]         r_row;
    logic [ARRAY_ROWS-1:0] r_lwe;
    logic                  r_v0;
    logic [ARRAY_ROWS-1:0] w_lane;
    logic                  w_res_valid;
    logic                  w_stall;
    logic                  w_shift_en;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_wt_rd;
    logic                  w_act_rd;
    logic                  w_done;

    assign w_stall    = w_res_valid & ~res_ready;
    assign w_shift_en = ~w_stall;
    assign w_accept   = w_res_valid & res_ready;
    assign w_start    = (r_state == IDLE) & cfg_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (!w_stall) begin
            r_state <= w_next;
        end
    end

    // Next-state decode; DRAIN exits on the final accepted result
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_load_weights) begin
                        w_next = LOAD_W;
                    end else if (cfg_num_vectors == '0) begin
                        w_next = DONE;
                    end else begin
                        w_next = STREAM;
                    end
                end
            end
            LOAD_W: begin
                if (r_row == ROW_END) begin
                    w_next = (r_num == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (r_vec == r_num - CNT_ONE) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_acc == r_num ||
                    (w_accept && r_acc == r_num - CNT_ONE)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Per-state strobes; reads are suppressed while stalled
    always_comb begin
        w_busy   = 1'b0;
        w_wt_rd  = 1'b0;
        w_act_rd = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            LOAD_W: begin
                w_busy  = 1'b1;
                w_wt_rd = ~w_stall & (r_row != ROW_END);
            end
            STREAM: begin
                w_busy   = 1'b1;
                w_act_rd = ~w_stall;
            end
            DRAIN: begin
                w_busy = 1'b1;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Job length latch plus row, issue and accept counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num <= '0;
            r_row <= '0;
            r_vec <= '0;
            r_acc <= '0;
        end else if (w_start) begin
            r_num <= cfg_num_vectors;
            r_row <= '0;
            r_vec <= '0;
            r_acc <= '0;
        end else if (r_state == DONE) begin
            r_vec <= '0;
            r_acc <= '0;
        end else if (!w_stall) begin
            if (w_wt_rd) begin
                r_row <= r_row + 1'b1;
            end
            if (r_state == LOAD_W && r_row == ROW_END) begin
                r_row <= '0;
            end
            if (w_act_rd) begin
                r_vec <= r_vec + CNT_ONE;
            end
            if (w_accept) begin
                r_acc <= r_acc + CNT_ONE;
            end
        end
    end

    // PE weight load strobe follows the buffer read by its 1-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lwe <= '0;
        end else if (w_wt_rd) begin
            r_lwe <= ARRAY_ROWS'(1) << r_row[RA_W-1:0];
        end else begin
            r_lwe <= '0;
        end
    end

    // Row-0 activation valid arrives one cycle after its buffer read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
        end else if (!w_stall) begin
            r_v0 <= w_act_rd;
        end
    end

    assign w_lane[0] = r_v0;

    generate
        for (genvar g = 1; g < ARRAY_ROWS; g++) begin : g_lane
            sa_delay_line #(
                .DEPTH(g * ROW_SKEW)
            ) u_lane (
                .clk  (clk),
                .rst_n(rst_n),
                .i_en (w_shift_en),
                .i_d  (r_v0),
                .o_q  (w_lane[g])
            );
        end
    endgenerate

    sa_delay_line #(
        .DEPTH(PIPE_LAT)
    ) u_res (
        .clk  (clk),
        .rst_n(rst_n),
        .i_en (w_shift_en),
        .i_d  (r_v0),
        .o_q  (w_res_valid)
    );

`ifdef SA_CTRL_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Saturating activity counters, cleared when a job is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_busy && r_perf_busy != '1) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if (w_stall && r_perf_stall != '1) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`endif

    assign wt_rd_en       = w_wt_rd;
    assign wt_rd_row      = w_wt_rd ? r_row[RA_W-1:0] : '0;
    assign load_weight_en = r_lwe;
    assign act_rd_en      = w_act_rd;
    assign act_rd_idx     = w_act_rd ? r_vec : '0;
    assign act_lane_en    = w_lane;
    assign pe_enable      = w_busy & ~w_stall;
    assign res_valid      = w_res_valid;
    assign res_idx        = r_acc;
    assign busy           = w_busy;
    assign done           = w_done;

endmodule

// File: tb/tb_systolic_array_controller.sv
// tb_systolic_array_controller: directed checks of the systolic array sequencer.
// Cycle k is counted from the first clock edge after cfg_start is sampled.
module tb_systolic_array_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_num_vectors = '0;
    logic        cfg_load_weights = 1'b0;
    logic        wt_rd_en;
    logic [1:0]  wt_rd_row;
    logic [3:0]  load_weight_en;
    logic        act_rd_en;
    logic [15:0] act_rd_idx;
    logic [3:0]  act_lane_en;
    logic        pe_enable;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_idx;
    logic        busy;
    logic        done;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    systolic_array_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_num_vectors (cfg_num_vectors),
        .cfg_load_weights(cfg_load_weights),
        .wt_rd_en        (wt_rd_en),
        .wt_rd_row       (wt_rd_row),
        .load_weight_en  (load_weight_en),
        .act_rd_en       (act_rd_en),
        .act_rd_idx      (act_rd_idx),
        .act_lane_en     (act_lane_en),
        .pe_enable       (pe_enable),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_idx         (res_idx),
        .busy            (busy),
`ifdef SA_CTRL_PERF_EN
        .perf_busy_cycles (perf_busy),
        .perf_stall_cycles(perf_stall),
`endif
        .done            (done)
    );

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n, input bit load);
        cfg_num_vectors  = 16'(n);
        cfg_load_weights = load;
        cfg_start        = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({wt_rd_en, wt_rd_row, load_weight_en, act_rd_en} !== 8'h00)
            $display("FAIL reset_wt_act got %h exp 00",
                     {wt_rd_en, wt_rd_row, load_weight_en, act_rd_en});
        else n_pass++;
        n_total++;
        if ({act_lane_en, pe_enable, res_valid, busy, done} !== 8'h00)
            $display("FAIL reset_ctl got %h exp 00",
                     {act_lane_en, pe_enable, res_valid, busy, done});
        else n_pass++;
        n_total++;
        if ({act_rd_idx, res_idx} !== 32'h0)
            $display("FAIL reset_idx got %h exp 0", {act_rd_idx, res_idx});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_load_only();
        logic [3:0] e_lwe;
        int dn = 0;
        start_job(0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            #1;
            e_lwe = (k >= 2 && k <= 5) ? 4'(1 << (k - 2)) : 4'b0000;
            n_total++;
            if (wt_rd_en !== (k >= 1 && k <= 4))
                $display("FAIL load_rd_en k=%0d got %b exp %b", k, wt_rd_en,
                         (k >= 1 && k <= 4));
            else n_pass++;
            if (k <= 4) begin
                n_total++;
                if (wt_rd_row !== 2'(k - 1))
                    $display("FAIL load_row k=%0d got %0d exp %0d", k, wt_rd_row, k - 1);
                else n_pass++;
            end
            n_total++;
            if (load_weight_en !== e_lwe)
                $display("FAIL load_lwe k=%0d got %b exp %b", k, load_weight_en, e_lwe);
            else n_pass++;
            n_total++;
            if (done !== (k == 6))
                $display("FAIL load_done k=%0d got %b exp %b", k, done, (k == 6));
            else n_pass++;
            n_total++;
            if (act_rd_en !== 1'b0)
                $display("FAIL load_act k=%0d got %b exp 0", k, act_rd_en);
            else n_pass++;
            if (done) dn++;
            @(posedge clk);
            #1;
        end
        n_total++;
        if (dn !== 1) $display("FAIL load_done_cnt got %0d exp 1", dn);
        else n_pass++;
    endtask

    task automatic test_stream3();
        int lane_first[4];
        int lane_cnt[4];
        int rd_first = 0;
        int rd_cnt = 0;
        int rv_cnt = 0;
        int dn_k = 0;
        int dn = 0;
        for (int r = 0; r < 4; r++) begin
            lane_first[r] = 0;
            lane_cnt[r] = 0;
        end
        res_ready = 1'b1;
        start_job(3, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (act_rd_en) begin
                if (rd_first == 0) rd_first = k;
                rd_cnt++;
                n_total++;
                if (act_rd_idx !== 16'(k - 1))
                    $display("FAIL s3_rd_idx k=%0d got %0d exp %0d", k, act_rd_idx, k - 1);
                else n_pass++;
            end
            for (int r = 0; r < 4; r++) begin
                if (act_lane_en[r]) begin
                    if (lane_first[r] == 0) lane_first[r] = k;
                    lane_cnt[r]++;
                end
            end
            n_total++;
            if (res_valid !== (k >= 13 && k <= 15))
                $display("FAIL s3_res_valid k=%0d got %b exp %b", k, res_valid,
                         (k >= 13 && k <= 15));
            else n_pass++;
            if (res_valid) begin
                rv_cnt++;
                n_total++;
                if (res_idx !== 16'(k - 13))
                    $display("FAIL s3_res_idx k=%0d got %0d exp %0d", k, res_idx, k - 13);
                else n_pass++;
            end
            if (done) begin
                dn++;
                dn_k = k;
                n_total++;
                if (busy !== 1'b0) $display("FAIL s3_busy_in_done got %b exp 0", busy);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        n_total++;
        if (rd_first !== 1 || rd_cnt !== 3)
            $display("FAIL s3_rd got first=%0d cnt=%0d exp first=1 cnt=3", rd_first, rd_cnt);
        else n_pass++;
        for (int r = 0; r < 4; r++) begin
            n_total++;
            if (lane_first[r] !== 2 + 2 * r || lane_cnt[r] !== 3)
                $display("FAIL s3_lane%0d got first=%0d cnt=%0d exp first=%0d cnt=3",
                         r, lane_first[r], lane_cnt[r], 2 + 2 * r);
            else n_pass++;
        end
        n_total++;
        if (lane_first[3] - rd_first !== 7)
            $display("FAIL s3_lane3_after_rd got %0d exp 7", lane_first[3] - rd_first);
        else n_pass++;
        n_total++;
        if (rv_cnt !== 3) $display("FAIL s3_res_cnt got %0d exp 3", rv_cnt);
        else n_pass++;
        n_total++;
        if (dn !== 1 || dn_k !== 16)
            $display("FAIL s3_done got cnt=%0d at=%0d exp cnt=1 at=16", dn, dn_k);
        else n_pass++;
    endtask

    task automatic test_stall();
        int pe_off = 0;
        int dn = 0;
        int acc_exp = 0;
        int e_idx;
        bit e_pe;
        start_job(5, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            res_ready = !(k >= 14 && k <= 17);
            #1;
            e_pe = (k <= 21) && !(k >= 14 && k <= 17);
            n_total++;
            if (pe_enable !== e_pe)
                $display("FAIL st_pe k=%0d got %b exp %b", k, pe_enable, e_pe);
            else n_pass++;
            if (!pe_enable && busy) pe_off++;
            n_total++;
            if (res_valid !== (k >= 13 && k <= 21))
                $display("FAIL st_res_valid k=%0d got %b exp %b", k, res_valid,
                         (k >= 13 && k <= 21));
            else n_pass++;
            if (k >= 13 && k <= 21) begin
                e_idx = (k < 14) ? 0 : (k <= 18) ? 1 : k - 17;
                n_total++;
                if (res_idx !== 16'(e_idx))
                    $display("FAIL st_res_idx k=%0d got %0d exp %0d", k, res_idx, e_idx);
                else n_pass++;
            end
            if (res_valid && res_ready) begin
                n_total++;
                if (res_idx !== 16'(acc_exp))
                    $display("FAIL st_order k=%0d got %0d exp %0d", k, res_idx, acc_exp);
                else n_pass++;
                acc_exp++;
            end
            if (act_rd_en) begin
                n_total++;
                if (k > 5 || act_rd_idx !== 16'(k - 1))
                    $display("FAIL st_rd k=%0d got idx=%0d exp k<=5 idx=%0d",
                             k, act_rd_idx, k - 1);
                else n_pass++;
            end
            n_total++;
            if (done !== (k == 22))
                $display("FAIL st_done k=%0d got %b exp %b", k, done, (k == 22));
            else n_pass++;
            if (done) dn++;
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        n_total++;
        if (pe_off !== 4) $display("FAIL st_pe_off_cnt got %0d exp 4", pe_off);
        else n_pass++;
        n_total++;
        if (acc_exp !== 5 || dn !== 1)
            $display("FAIL st_totals got acc=%0d done=%0d exp acc=5 done=1", acc_exp, dn);
        else n_pass++;
`ifdef SA_CTRL_PERF_EN
        n_total++;
        if (perf_busy !== 32'd21 || perf_stall !== 32'd4)
            $display("FAIL st_perf got busy=%0d stall=%0d exp busy=21 stall=4",
                     perf_busy, perf_stall);
        else n_pass++;
`endif
    endtask

    task automatic test_ignore_start();
        int dn = 0;
        int rd = 0;
        start_job(2, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            cfg_start = (k == 3 || k == 15);
            cfg_load_weights = (k == 3);
            cfg_num_vectors = (k == 3) ? 16'd7 : 16'd3;
            #1;
            n_total++;
            if (busy !== (k <= 14))
                $display("FAIL ign_busy k=%0d got %b exp %b", k, busy, (k <= 14));
            else n_pass++;
            n_total++;
            if (wt_rd_en !== 1'b0)
                $display("FAIL ign_wt_rd k=%0d got %b exp 0", k, wt_rd_en);
            else n_pass++;
            if (act_rd_en) rd++;
            if (done) dn++;
            @(posedge clk);
            #1;
        end
        cfg_start = 1'b0;
        cfg_load_weights = 1'b0;
        n_total++;
        if (rd !== 2 || dn !== 1)
            $display("FAIL ign_totals got rd=%0d done=%0d exp rd=2 done=1", rd, dn);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit e_busy;
        start_job(1, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            cfg_start = (k == 15);
            cfg_num_vectors = 16'd1;
            cfg_load_weights = 1'b0;
            #1;
            e_busy = (k >= 1 && k <= 13) || (k >= 16 && k <= 28);
            n_total++;
            if (busy !== e_busy)
                $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy, e_busy);
            else n_pass++;
            n_total++;
            if (act_rd_en !== (k == 1 || k == 16))
                $display("FAIL b2b_rd k=%0d got %b exp %b", k, act_rd_en,
                         (k == 1 || k == 16));
            else n_pass++;
            n_total++;
            if (res_valid !== (k == 13 || k == 28))
                $display("FAIL b2b_res k=%0d got %b exp %b", k, res_valid,
                         (k == 13 || k == 28));
            else n_pass++;
            if (res_valid) begin
                n_total++;
                if (res_idx !== 16'd0)
                    $display("FAIL b2b_res_idx k=%0d got %0d exp 0", k, res_idx);
                else n_pass++;
            end
            n_total++;
            if (done !== (k == 14 || k == 29))
                $display("FAIL b2b_done k=%0d got %b exp %b", k, done,
                         (k == 14 || k == 29));
            else n_pass++;
`ifdef SA_CTRL_PERF_EN
            if (k == 14 || k == 29) begin
                n_total++;
                if (perf_busy !== 32'd13 || perf_stall !== 32'd0)
                    $display("FAIL b2b_perf k=%0d got busy=%0d stall=%0d exp 13/0",
                             k, perf_busy, perf_stall);
                else n_pass++;
            end
`endif
            @(posedge clk);
            #1;
        end
        cfg_start = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        int dn = 0;
        int bz = 0;
        start_job(5, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (pe_enable !== 1'b1)
            $display("FAIL rst_mid_pe_before got %b exp 1", pe_enable);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({pe_enable, busy, done, act_rd_en, res_valid, wt_rd_en} !== 6'b0)
            $display("FAIL rst_mid_ctl got %b exp 000000",
                     {pe_enable, busy, done, act_rd_en, res_valid, wt_rd_en});
        else n_pass++;
        n_total++;
        if ({act_lane_en, load_weight_en, act_rd_idx, res_idx} !== 40'h0)
            $display("FAIL rst_mid_data got %h exp 0",
                     {act_lane_en, load_weight_en, act_rd_idx, res_idx});
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (done) dn++;
            if (busy || res_valid || act_lane_en != 4'b0) bz++;
            @(posedge clk);
            #1;
        end
        n_total++;
        if (dn !== 0 || bz !== 0)
            $display("FAIL rst_mid_after got done=%0d active=%0d exp 0/0", dn, bz);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_only();
        idle(2);
        test_stream3();
        idle(2);
        test_stall();
        idle(2);
        test_ignore_start();
        idle(2);
        test_back_to_back();
        idle(2);
        test_reset_mid_job();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
